// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the lane-count arbiter / pedestrian / emergency inputs
// and the phase sequencer outputs; the sequencer attaches through the slave modport.
interface traffic_phase_sequencer_if;
  logic       tick;
  logic [1:0] reqDir;
  logic [8:0] reqCount;
  logic       pedReq;
  logic       emergReq;
  logic [1:0] emergDir;
  logic [7:0] laneOutput;
  logic [3:0] yellow;
  logic [1:0] greenDir;
  logic       advance;
  logic       pedAck;
  logic [6:0] timerValue;

  modport master (
    output tick, reqDir, reqCount, pedReq, emergReq, emergDir,
    input  laneOutput, yellow, greenDir, advance, pedAck, timerValue
  );

  modport slave (
    input  tick, reqDir, reqCount, pedReq, emergReq, emergDir,
    output laneOutput, yellow, greenDir, advance, pedAck, timerValue
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Timed GREEN / YELLOW / ALL_RED / WALK phase controller driven by a 1 Hz tick.
// Define EMERGENCY_PREEMPT_EN to enable emergency-vehicle preemption.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ALL_RED | clearance; on expiry picks emergency, walk or next green
// GREEN   | greenDir has right of way
// YELLOW  | greenDir clearing, then ALL_RED
// WALK    | pedestrian crossing, all vehicle lights red
module traffic_phase_sequencer #(
  parameter int GREEN_BASE = 20,
  parameter int GREEN_MAX  = 60,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 2,
  parameter int WALK_T     = 10
) (
  input logic clk,
  input logic rst,
  traffic_phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW, WALK} phaseT;

  phaseT      phase;
  logic [6:0] timer;
  logic [1:0] greenDirQ;
  logic       pedPending;
  logic [7:0] laneQ;
  logic [3:0] yellowQ;
  logic       advanceQ;
  logic       pedAckQ;

  logic       emergOn;
  logic       pedNow;
  logic       expiry;
  logic       preempt;
  logic       frozen;
  logic [9:0] greenSum;
  logic [6:0] reqLoad;
  logic [1:0] nextDir;
  logic [6:0] nextLoad;

`ifdef EMERGENCY_PREEMPT_EN
  assign emergOn = bus.emergReq;
`else
  logic unusedEmergReq;
  assign unusedEmergReq = bus.emergReq;
  assign emergOn        = 1'b0;
`endif

  function automatic logic [7:0] laneMask(input logic [1:0] d);
    return 8'h03 << {d, 1'b0};
  endfunction

  // Walk request seen this cycle is honoured even on the ALL_RED expiry cycle.
  assign pedNow  = pedPending | (bus.pedReq & (phase != WALK));
  assign expiry  = bus.tick & (timer == 7'd1);
  assign preempt = emergOn & (phase == GREEN) & (bus.emergDir != greenDirQ);
  assign frozen  = emergOn & (phase == GREEN) & (bus.emergDir == greenDirQ);

  // Sum kept at 10 bits so a large count saturates instead of wrapping.
  always_comb begin
    greenSum = 10'(GREEN_BASE) + {2'b00, bus.reqCount[8:1]};
    reqLoad  = (greenSum > 10'(GREEN_MAX)) ? 7'(GREEN_MAX) : greenSum[6:0];
  end

  always_comb begin
    nextDir  = bus.reqDir;
    nextLoad = reqLoad;
    if (emergOn) begin
      nextDir  = bus.emergDir;
      nextLoad = 7'(GREEN_MAX);
    end else if (bus.reqCount == 9'd0) begin
      nextDir  = greenDirQ + 2'd1;
      nextLoad = 7'(GREEN_BASE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= ALL_RED;
      timer      <= 7'(ALLRED_T);
      greenDirQ  <= 2'd0;
      pedPending <= 1'b0;
      laneQ      <= 8'd0;
      yellowQ    <= 4'd0;
      advanceQ   <= 1'b0;
      pedAckQ    <= 1'b0;
    end else begin
      advanceQ   <= 1'b0;
      pedAckQ    <= 1'b0;
      pedPending <= pedNow;
      case (phase)
        ALL_RED: begin
          if (expiry) begin
            if (pedNow && !emergOn) begin
              phase      <= WALK;
              timer      <= 7'(WALK_T);
              pedAckQ    <= 1'b1;
              pedPending <= 1'b0;
            end else begin
              phase     <= GREEN;
              timer     <= nextLoad;
              greenDirQ <= nextDir;
              laneQ     <= laneMask(nextDir);
              advanceQ  <= 1'b1;
            end
          end else if (bus.tick) begin
            timer <= timer - 7'd1;
          end
        end
        GREEN: begin
          if (preempt || (expiry && !frozen)) begin
            phase   <= YELLOW;
            timer   <= 7'(YELLOW_T);
            laneQ   <= 8'd0;
            yellowQ <= 4'b0001 << greenDirQ;
          end else if (bus.tick && !frozen) begin
            timer <= timer - 7'd1;
          end
        end
        YELLOW: begin
          if (expiry) begin
            phase   <= ALL_RED;
            timer   <= 7'(ALLRED_T);
            yellowQ <= 4'd0;
          end else if (bus.tick) begin
            timer <= timer - 7'd1;
          end
        end
        WALK: begin
          if (expiry) begin
            phase <= ALL_RED;
            timer <= 7'(ALLRED_T);
          end else if (bus.tick) begin
            timer <= timer - 7'd1;
          end
        end
      endcase
    end
  end

  assign bus.laneOutput = laneQ;
  assign bus.yellow     = yellowQ;
  assign bus.greenDir   = greenDirQ;
  assign bus.advance    = advanceQ;
  assign bus.pedAck     = pedAckQ;
  assign bus.timerValue = timer;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: a phase-level reference model is
// compared every cycle, plus hand-computed expectations at key points.
module tb_traffic_phase_sequencer;
  localparam int GREEN_BASE = 20;
  localparam int GREEN_MAX  = 60;
  localparam int YELLOW_T   = 3;
  localparam int ALLRED_T   = 2;
  localparam int WALK_T     = 10;
`ifdef EMERGENCY_PREEMPT_EN
  localparam bit EMERG = 1'b1;
`else
  localparam bit EMERG = 1'b0;
`endif

  localparam int M_RED = 0, M_GRN = 1, M_YEL = 2, M_WLK = 3;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   cmpOn  = 1'b0;

  traffic_phase_sequencer_if bus ();

  traffic_phase_sequencer #(
    .GREEN_BASE(GREEN_BASE), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: current phase, ticks left, served direction, walk latch.
  int mPhase = M_RED;
  int mLeft  = ALLRED_T;
  int mDir   = 0;
  bit mPed   = 1'b0;
  bit mAdv   = 1'b0;
  bit mAck   = 1'b0;

  task automatic startGreen(input int d, input int dur);
    mPhase = M_GRN;
    mDir   = d;
    mLeft  = dur;
    mAdv   = 1'b1;
  endtask

  initial begin
    bit em, ped;
    forever begin
      @(posedge clk);
      if (rst) begin
        mPhase = M_RED; mLeft = ALLRED_T; mDir = 0;
        mPed = 1'b0; mAdv = 1'b0; mAck = 1'b0;
      end else begin
        em   = EMERG && bus.emergReq;
        ped  = mPed || (bus.pedReq && mPhase != M_WLK);
        mAdv = 1'b0;
        mAck = 1'b0;
        if (em && mPhase == M_GRN && int'(bus.emergDir) != mDir) begin
          mPhase = M_YEL;
          mLeft  = YELLOW_T;
        end else if (bus.tick && !(em && mPhase == M_GRN)) begin
          if (mLeft > 1) mLeft = mLeft - 1;
          else begin
            case (mPhase)
              M_RED: begin
                if (em) startGreen(int'(bus.emergDir), GREEN_MAX);
                else if (ped) begin
                  mPhase = M_WLK; mLeft = WALK_T; mAck = 1'b1; ped = 1'b0;
                end else if (bus.reqCount == 0) startGreen((mDir + 1) % 4, GREEN_BASE);
                else begin
                  int d;
                  d = GREEN_BASE + int'(bus.reqCount) / 2;
                  startGreen(int'(bus.reqDir), (d > GREEN_MAX) ? GREEN_MAX : d);
                end
              end
              M_GRN: begin mPhase = M_YEL; mLeft = YELLOW_T; end
              default: begin mPhase = M_RED; mLeft = ALLRED_T; end
            endcase
          end
        end
        mPed = ped;
      end
    end
  end

  function automatic int expLane();
    return (mPhase == M_GRN) ? (3 << (2 * mDir)) : 0;
  endfunction

  function automatic int expYellow();
    return (mPhase == M_YEL) ? (1 << mDir) : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmpOn) begin
        chk("model laneOutput", int'(bus.laneOutput), expLane());
        chk("model yellow", int'(bus.yellow), expYellow());
        chk("model greenDir", int'(bus.greenDir), mDir);
        chk("model advance", int'(bus.advance), int'(mAdv));
        chk("model pedAck", int'(bus.pedAck), int'(mAck));
        chk("model timerValue", int'(bus.timerValue), mLeft);
      end
    end
  end

  task automatic tickN(input int n);
    repeat (n) begin
      bus.tick = 1'b1;
      @(negedge clk);
    end
    bus.tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.tick = 1'b0; bus.reqDir = 2'd0; bus.reqCount = 9'd0;
    bus.pedReq = 1'b0; bus.emergReq = 1'b0; bus.emergDir = 2'd0;
    idle(2);
    rst = 1'b0;
    cmpOn = 1'b1;
    chk("reset timer", int'(bus.timerValue), 2);
    chk("reset lane", int'(bus.laneOutput), 0);
    chk("reset yellow", int'(bus.yellow), 0);
    chk("reset greenDir", int'(bus.greenDir), 0);

    bus.reqDir = 2'd2; bus.reqCount = 9'd40;
    tickN(2);
    chk("first green dir", int'(bus.greenDir), 2);
    chk("first green lane", int'(bus.laneOutput), 8'h30);
    chk("first green advance", int'(bus.advance), 1);
    chk("first green timer", int'(bus.timerValue), 40);
    idle(1);
    chk("advance one cycle", int'(bus.advance), 0);
    tickN(40);
    chk("yellow S", int'(bus.yellow), 4'b0100);
    chk("yellow timer", int'(bus.timerValue), 3);
    tickN(3);
    chk("allred timer", int'(bus.timerValue), 2);

    bus.reqDir = 2'd3; bus.reqCount = 9'd200;
    tickN(2);
    chk("saturated timer", int'(bus.timerValue), 60);
    chk("W lane", int'(bus.laneOutput), 8'hC0);
    tickN(63);
    bus.reqCount = 9'd0;
    tickN(2);
    chk("rotate dir", int'(bus.greenDir), 0);
    chk("rotate timer", int'(bus.timerValue), 20);

    tickN(5);
    bus.pedReq = 1'b1;
    idle(1);
    bus.pedReq = 1'b0;
    tickN(18);
    bus.reqDir = 2'd1; bus.reqCount = 9'd10;
    tickN(2);
    chk("walk pedAck", int'(bus.pedAck), 1);
    chk("walk lane", int'(bus.laneOutput), 0);
    chk("walk timer", int'(bus.timerValue), 10);
    idle(1);
    chk("pedAck one cycle", int'(bus.pedAck), 0);
    tickN(12);
    chk("after walk green E", int'(bus.greenDir), 1);
    chk("after walk timer", int'(bus.timerValue), 25);

    tickN(29);
    bus.tick = 1'b1; bus.pedReq = 1'b1;
    idle(1);
    bus.tick = 1'b0; bus.pedReq = 1'b0;
    chk("same-cycle ped", int'(bus.pedAck), 1);
    tickN(10);
    bus.reqDir = 2'd0; bus.reqCount = 9'd40;
    tickN(2);
    chk("green N timer", int'(bus.timerValue), 40);

    bus.emergReq = 1'b1; bus.emergDir = 2'd1;
    idle(1);
`ifdef EMERGENCY_PREEMPT_EN
    chk("preempt yellow", int'(bus.yellow), 4'b0001);
    chk("preempt timer", int'(bus.timerValue), 3);
    tickN(5);
    chk("emerg green dir", int'(bus.greenDir), 1);
    chk("emerg green timer", int'(bus.timerValue), 60);
    tickN(5);
    chk("frozen timer", int'(bus.timerValue), 60);
    bus.emergReq = 1'b0;
    tickN(1);
    chk("unfrozen timer", int'(bus.timerValue), 59);
`else
    chk("no preempt lane", int'(bus.laneOutput), 8'h03);
    chk("no preempt timer", int'(bus.timerValue), 40);
    tickN(5);
    chk("no freeze timer", int'(bus.timerValue), 35);
    bus.emergReq = 1'b0;
`endif

    n = mLeft;
    tickN(n + 1);
    chk("yellow before reset", int'(bus.timerValue), 2);
    rst = 1'b1; bus.tick = 1'b1; bus.pedReq = 1'b1; bus.emergReq = 1'b1;
    idle(1);
    rst = 1'b0; bus.tick = 1'b0; bus.pedReq = 1'b0; bus.emergReq = 1'b0;
    chk("mid reset timer", int'(bus.timerValue), 2);
    chk("mid reset yellow", int'(bus.yellow), 0);
    chk("mid reset lane", int'(bus.laneOutput), 0);
    chk("mid reset greenDir", int'(bus.greenDir), 0);

    bus.reqDir = 2'd3; bus.reqCount = 9'd1;
    tickN(2);
    chk("post reset green W", int'(bus.laneOutput), 8'hC0);
    chk("post reset timer", int'(bus.timerValue), 20);
    tickN(23);
    bus.reqDir = 2'd2; bus.reqCount = 9'd510;
    tickN(2);
    chk("max count timer", int'(bus.timerValue), 60);
    chk("max count dir", int'(bus.greenDir), 2);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
